// File: rtl/pio_debounced_irq.sv
// Avalon-MM PIO: synchronised and debounced inputs, outputs with atomic set/clear,
// sticky per-bit edge capture and a registered, maskable level interrupt.
module pio_debounced_irq #(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 8,
  parameter int CNT_W     = 20,
  parameter int DEB_RESET = 50000,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [IN_W-1:0]  in_export,
  output logic [OUT_W-1:0] out_export,
  output logic             irq
);

  typedef enum logic [2:0] {
    A_DATA_IN  = 3'd0,
    A_DATA_OUT = 3'd1,
    A_IRQ_MASK = 3'd2,
    A_EDGE_CAP = 3'd3,
    A_OUT_SET  = 3'd4,
    A_OUT_CLR  = 3'd5,
    A_DEBOUNCE = 3'd6,
    A_RESERVED = 3'd7
  } regAddr_e;

  localparam logic [CNT_W-1:0] DEB_INIT = CNT_W'(DEB_RESET);

  regAddr_e         addr;
  logic [IN_W-1:0]  sync1_q, sync2_q;
  logic [IN_W-1:0]  stable_q, stable_d, stablePrev_q;
  logic [CNT_W-1:0] cnt_q [IN_W];
  logic [CNT_W-1:0] cnt_d [IN_W];
  logic [CNT_W-1:0] deb_q, deb_d;
  logic [IN_W-1:0]  mask_q, mask_d;
  logic [IN_W-1:0]  edgeCap_q, edgeCap_d;
  logic [IN_W-1:0]  riseDet, fallDet, edgeDet;
  logic [OUT_W-1:0] dataOut_q, dataOut_d;
  logic [31:0]      readData_q, readData_d;
  logic             irq_q, irq_d;
  logic             unusedWdata;

  assign addr = regAddr_e'(avs_address);
  // Upper write-data bits beyond the register widths are intentionally ignored.
  assign unusedWdata = ^avs_writedata;

  // Debouncer: the incremented count is compared one bit wider so it can never wrap.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < IN_W; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, deb_q}) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign riseDet = stable_q & ~stablePrev_q;
  assign fallDet = ~stable_q & stablePrev_q;

  always_comb begin
    if (EDGE_MODE == 0)      edgeDet = riseDet;
    else if (EDGE_MODE == 1) edgeDet = fallDet;
    else                     edgeDet = riseDet | fallDet;
  end

  // A new edge is OR-ed in after the W1C clear so it survives a coincident clear.
  always_comb begin
    dataOut_d = dataOut_q;
    mask_d    = mask_q;
    deb_d     = deb_q;
    edgeCap_d = edgeCap_q;
    if (avs_write) begin
      case (addr)
        A_DATA_OUT: dataOut_d = avs_writedata[OUT_W-1:0];
        A_IRQ_MASK: mask_d    = avs_writedata[IN_W-1:0];
        A_EDGE_CAP: edgeCap_d = edgeCap_q & ~avs_writedata[IN_W-1:0];
        A_OUT_SET:  dataOut_d = dataOut_q | avs_writedata[OUT_W-1:0];
        A_OUT_CLR:  dataOut_d = dataOut_q & ~avs_writedata[OUT_W-1:0];
        A_DEBOUNCE: deb_d     = avs_writedata[CNT_W-1:0];
        default:    ;
      endcase
    end
    edgeCap_d = edgeCap_d | edgeDet;
  end

  always_comb begin
    readData_d = '0;
    if (avs_read && !avs_write) begin
      case (addr)
        A_DATA_IN:  readData_d = 32'(stable_q);
        A_DATA_OUT: readData_d = 32'(dataOut_q);
        A_IRQ_MASK: readData_d = 32'(mask_q);
        A_EDGE_CAP: readData_d = 32'(edgeCap_q);
        A_DEBOUNCE: readData_d = 32'(deb_q);
        A_OUT_SET, A_OUT_CLR, A_RESERVED: readData_d = '0;
        default:    readData_d = '0;
      endcase
    end
  end

  assign irq_d = |(edgeCap_q & mask_q);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      stablePrev_q <= '0;
      deb_q        <= DEB_INIT;
      mask_q       <= '0;
      edgeCap_q    <= '0;
      dataOut_q    <= '0;
      readData_q   <= '0;
      irq_q        <= 1'b0;
      for (int i = 0; i < IN_W; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q      <= in_export;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stablePrev_q <= stable_q;
      deb_q        <= deb_d;
      mask_q       <= mask_d;
      edgeCap_q    <= edgeCap_d;
      dataOut_q    <= dataOut_d;
      readData_q   <= readData_d;
      irq_q        <= irq_d;
      for (int i = 0; i < IN_W; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign avs_readdata = readData_q;
  assign out_export   = dataOut_q;
  assign irq          = irq_q;

endmodule
